// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//
// Front-end controller for the instruction-address (IA) stage. Each cycle it
// presents a 12-bit PC and a fetch enable to the IA stage. It handles
// run/halt control, sequential increment, branch redirect with a one-cycle
// flush pulse, and downstream stall back-pressure. It also counts issued
// fetches for debug.
//
// An issue is a cycle where enable_out=1 and stall=0.
//
// Ports:
//   clk           in   1      system clock; all state changes on the rising edge
//   rst           in   1      synchronous active-high reset
//   run           in   1      level; start or resume fetching
//   halt_req      in   1      level; stop fetching at the next cycle boundary
//   stall         in   1      downstream cannot accept this cycle's fetch
//   branch_valid  in   1      one-cycle pulse; redirect the PC
//   branch_target in   12     redirect address, sampled with branch_valid
//   enable_out    out  1      registered fetch request to the IA stage
//   pc_out        out  12     registered PC of the current fetch
//   flush_out     out  1      registered one-cycle flush pulse per branch
//   state_out     out  2      00 IDLE, 01 RUN, 10 HALT
//   fetch_cnt     out  CNT_W  issued-fetch count; wraps silently
// ----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [11:0] RESET_VEC = 12'h000,
  parameter logic [11:0] PC_STEP   = 12'd1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic             stall,
  input  logic             branch_valid,
  input  logic [11:0]      branch_target,
  output logic             enable_out,
  output logic [11:0]      pc_out,
  output logic             flush_out,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic               enable_r;
  logic               enable_next_s;
  logic [11:0]        pc_r;
  logic [11:0]        pc_next_s;
  logic               flush_r;
  logic               flush_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic               issue_s;

  // A fetch is issued when a request is outstanding and downstream accepts it.
  always_comb begin
    issue_s = enable_r & ~stall;
  end

  // Next-state and next-output decode for the run/halt sequencer.
  always_comb begin
    state_next_s  = state_r;
    enable_next_s = 1'b0;
    pc_next_s     = pc_r;
    flush_next_s  = 1'b0;
    cnt_next_s    = cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (run && !halt_req) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_next_s = ST_HALT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        // Both run and halt_req high keeps the sequencer halted.
        if (run && !halt_req) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // The fetch request simply mirrors being in RUN on the next cycle; a
    // stalled fetch therefore stays requested and is retried.
    if (state_next_s == ST_RUN) begin
      enable_next_s = 1'b1;
    end else begin
      enable_next_s = 1'b0;
    end

    // Branch wins over increment and over stall. An issue in the branch
    // cycle is still counted, but its increment is dropped.
    if (branch_valid) begin
      pc_next_s = branch_target;
    end else if (issue_s) begin
      pc_next_s = pc_r + PC_STEP;
    end else begin
      pc_next_s = pc_r;
    end

    if (branch_valid) begin
      flush_next_s = 1'b1;
    end else begin
      flush_next_s = 1'b0;
    end

    if (issue_s) begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State and output registers; reset overrides any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      enable_r <= 1'b0;
      pc_r     <= RESET_VEC;
      flush_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      enable_r <= enable_next_s;
      pc_r     <= pc_next_s;
      flush_r  <= flush_next_s;
      cnt_r    <= cnt_next_s;
    end
  end

  assign enable_out = enable_r;
  assign pc_out     = pc_r;
  assign flush_out  = flush_r;
  assign state_out  = state_r;
  assign fetch_cnt  = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer. Each call of step() drives one cycle
// of inputs on the falling edge, pushes the expected post-edge outputs into a
// scoreboard queue, and pops/compares them just after the rising edge.
// Directed constant checks cover the key scenarios, followed by random
// traffic checked against the same reference model.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic        halt_req;
  logic        stall;
  logic        branch_valid;
  logic [11:0] branch_target;
  logic        enable_out;
  logic [11:0] pc_out;
  logic        flush_out;
  logic [1:0]  state_out;
  logic [15:0] fetch_cnt;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        en;
    logic [11:0] pc;
    logic        flush;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic        m_en;
  logic [11:0] m_pc;
  logic        m_flush;
  logic [1:0]  m_st;
  logic [15:0] m_cnt;

  pc_sequencer #(
    .RESET_VEC(12'h000),
    .PC_STEP  (12'd1),
    .CNT_W    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .halt_req     (halt_req),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .enable_out   (enable_out),
    .pc_out       (pc_out),
    .flush_out    (flush_out),
    .state_out    (state_out),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: compute outputs after the next edge from current model
  // state and the inputs being driven.
  task automatic model_step(input logic r, input logic rn, input logic h,
                            input logic s, input logic bv, input logic [11:0] bt);
    logic       iss;
    logic [1:0] ns;
    iss = m_en && !s;
    if (r) begin
      m_st = 2'b00; m_en = 1'b0; m_pc = 12'h000; m_flush = 1'b0; m_cnt = 16'd0;
    end else begin
      ns = m_st;
      if (m_st == 2'b00) ns = (rn && !h) ? 2'b01 : 2'b00;
      else if (m_st == 2'b01) ns = h ? 2'b10 : 2'b01;
      else ns = (rn && !h) ? 2'b01 : 2'b10;
      if (bv) m_pc = bt;
      else if (iss) m_pc = m_pc + 12'd1;
      if (iss) m_cnt = m_cnt + 16'd1;
      m_flush = bv;
      m_st = ns;
      m_en = (ns == 2'b01);
    end
  endtask

  task automatic step(input logic r, input logic rn, input logic h,
                      input logic s, input logic bv, input logic [11:0] bt);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; run = rn; halt_req = h; stall = s;
    branch_valid = bv; branch_target = bt;
    model_step(r, rn, h, s, bv, bt);
    e.en = m_en; e.pc = m_pc; e.flush = m_flush; e.st = m_st; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_val("sb_en",    {31'd0, enable_out}, {31'd0, got.en});
      check_val("sb_pc",    {20'd0, pc_out},     {20'd0, got.pc});
      check_val("sb_flush", {31'd0, flush_out},  {31'd0, got.flush});
      check_val("sb_state", {30'd0, state_out},  {30'd0, got.st});
      check_val("sb_cnt",   {16'd0, fetch_cnt},  {16'd0, got.cnt});
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; stall = 1'b0;
    branch_valid = 1'b0; branch_target = 12'h000;
    m_en = 1'b0; m_pc = 12'h000; m_flush = 1'b0; m_st = 2'b00; m_cnt = 16'd0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("rst_pc",    {20'd0, pc_out},    32'h000);
    check_val("rst_en",    {31'd0, enable_out}, 32'd0);
    check_val("rst_state", {30'd0, state_out}, 32'd0);
    check_val("rst_cnt",   {16'd0, fetch_cnt}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("idle_en",   {31'd0, enable_out}, 32'd0);

    // Run from reset vector
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("run_en1", {31'd0, enable_out}, 32'd1);
    check_val("run_pc0", {20'd0, pc_out},     32'h000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("run_pc3",  {20'd0, pc_out},    32'h003);
    check_val("run_cnt3", {16'd0, fetch_cnt}, 32'd3);

    // Stall at 005
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("pre_stall_pc", {20'd0, pc_out}, 32'h005);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      check_val("stall_pc",  {20'd0, pc_out},     32'h005);
      check_val("stall_en",  {31'd0, enable_out}, 32'd1);
      check_val("stall_cnt", {16'd0, fetch_cnt},  32'd5);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("unstall_pc", {20'd0, pc_out}, 32'h006);

    // Branch under stall
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h010);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
    check_val("pre_br_pc",    {20'd0, pc_out},    32'h010);
    check_val("pre_br_flush", {31'd0, flush_out}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h3A0);
    check_val("br_pc",    {20'd0, pc_out},    32'h3A0);
    check_val("br_flush", {31'd0, flush_out}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("br_flush_off", {31'd0, flush_out}, 32'd0);

    // PC wrap
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFFE);
    check_val("wrap_ffe", {20'd0, pc_out}, 32'hFFE);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("wrap_fff", {20'd0, pc_out}, 32'hFFF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("wrap_000", {20'd0, pc_out}, 32'h000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("wrap_001", {20'd0, pc_out}, 32'h001);

    // Halt with branch in the same cycle
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h120);
    check_val("hb_en",    {31'd0, enable_out}, 32'd0);
    check_val("hb_state", {30'd0, state_out},  32'd2);
    check_val("hb_pc",    {20'd0, pc_out},     32'h120);
    check_val("hb_flush", {31'd0, flush_out},  32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    check_val("hold_state", {30'd0, state_out}, 32'd2);
    check_val("hold_pc",    {20'd0, pc_out},    32'h120);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check_val("resume_en", {31'd0, enable_out}, 32'd1);
    check_val("resume_pc", {20'd0, pc_out},     32'h120);

    // Back-to-back branches
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h111);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h222);
    check_val("b2b_pc",    {20'd0, pc_out},    32'h222);
    check_val("b2b_flush", {31'd0, flush_out}, 32'd1);

    // Reset mid-run with a branch pending
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h44C);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h3A0);
    check_val("mrst_pc",    {20'd0, pc_out},     32'h000);
    check_val("mrst_en",    {31'd0, enable_out}, 32'd0);
    check_val("mrst_flush", {31'd0, flush_out},  32'd0);
    check_val("mrst_cnt",   {16'd0, fetch_cnt},  32'd0);
    check_val("mrst_state", {30'd0, state_out},  32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
           12'($urandom_range(0, 4095)));
    end

    check_val("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
